// File: rtl/brg_hcc_req_fifo.sv
// Outgoing-request FIFO between the HCC core request port and the manycore endpoint.
// Optional stall statistic counter enabled by defining BRG_HCC_REQ_FIFO_STATS_EN.
module brg_hcc_req_fifo #(
    parameter int packet_width_p    = 76,
    parameter int els_p             = 4,
    parameter int max_out_credits_p = 200,
    parameter int credit_reserve_p  = 0,
    parameter int credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          freeze_i,
    input  logic                          in_v_i,
    input  logic [packet_width_p-1:0]     in_packet_i,
    output logic                          in_ready_o,
    output logic                          out_v_o,
    output logic [packet_width_p-1:0]     out_packet_o,
    input  logic                          out_credit_or_ready_i,
    input  logic [credit_width_lp-1:0]    out_credits_i,
    output logic [$clog2(els_p+1)-1:0]    count_o,
    output logic                          empty_o,
    output logic [31:0]                   stall_cycles_o
);

    localparam int ptr_width = $clog2(els_p);
    localparam int cnt_width = $clog2(els_p + 1);

    localparam logic [cnt_width-1:0]       cnt_full = cnt_width'(els_p);
    localparam logic [credit_width_lp-1:0] reserve  = credit_width_lp'(credit_reserve_p);

    localparam logic [0:0] FROZEN = 1'b0;
    localparam logic [0:0] RUN    = 1'b1;

    logic [packet_width_p-1:0] mem [els_p];
    logic [ptr_width-1:0]      wptr;
    logic [ptr_width-1:0]      rptr;
    logic [cnt_width-1:0]      count;
    logic [0:0]                state;
    logic                      enq;
    logic                      deq;
    logic                      not_empty;

    assign not_empty    = (count != '0);
    assign in_ready_o   = (count != cnt_full);
    assign enq          = in_v_i & in_ready_o;
    // Issue never looks at ready, so ready may depend on out_v_o without a loop.
    assign out_v_o      = (state == RUN) & not_empty & (out_credits_i > reserve);
    assign deq          = out_v_o & out_credit_or_ready_i;
    assign out_packet_o = mem[rptr];
    assign count_o      = count;
    assign empty_o      = ~not_empty;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr] <= in_packet_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            state <= FROZEN;
        end else begin
            state <= freeze_i ? FROZEN : RUN;
            if (enq) begin
                wptr <= wptr + ptr_width'(1);
            end
            if (deq) begin
                rptr <= rptr + ptr_width'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + cnt_width'(1);
                2'b01:   count <= count - cnt_width'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef BRG_HCC_REQ_FIFO_STATS_EN
    logic [31:0] stall_cycles;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cycles <= '0;
        end else if (not_empty && !deq && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cycles;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_brg_hcc_req_fifo.sv
// Self-checking bench for brg_hcc_req_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_brg_hcc_req_fifo;

    localparam int PW  = 16;
    localparam int ELS = 4;
    localparam int RES = 2;
    localparam int CW  = $clog2(200 + 1);
    localparam int NW  = $clog2(ELS + 1);

    logic          clk = 1'b0;
    logic          reset_i;
    logic          freeze_i;
    logic          in_v_i;
    logic [PW-1:0] in_packet_i;
    logic          in_ready_o;
    logic          out_v_o;
    logic [PW-1:0] out_packet_o;
    logic          out_credit_or_ready_i;
    logic [CW-1:0] out_credits_i;
    logic [NW-1:0] count_o;
    logic          empty_o;
    logic [31:0]   stall_cycles_o;

    brg_hcc_req_fifo #(
        .packet_width_p   (PW),
        .els_p            (ELS),
        .max_out_credits_p(200),
        .credit_reserve_p (RES)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .freeze_i             (freeze_i),
        .in_v_i               (in_v_i),
        .in_packet_i          (in_packet_i),
        .in_ready_o           (in_ready_o),
        .out_v_o              (out_v_o),
        .out_packet_o         (out_packet_o),
        .out_credit_or_ready_i(out_credit_or_ready_i),
        .out_credits_i        (out_credits_i),
        .count_o              (count_o),
        .empty_o              (empty_o),
        .stall_cycles_o       (stall_cycles_o)
    );

    always #5 clk = ~clk;

    int unsigned   vectors = 0;
    int unsigned   errors  = 0;

    // Reference model state
    logic [PW-1:0] q[$];
    bit            m_run;
    longint        m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_stall();
`ifdef BRG_HCC_REQ_FIFO_STATS_EN
        return (m_stall > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_stall);
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_run   = 1'b0;
        m_stall = 0;
    endtask

    task automatic check_outputs(input string tag);
        bit exp_ready;
        bit exp_v;
        exp_ready = (q.size() != ELS);
        exp_v     = m_run && (q.size() != 0) && (int'(out_credits_i) > RES);
        chk({tag, ".in_ready"}, 64'(in_ready_o), 64'(exp_ready));
        chk({tag, ".out_v"},    64'(out_v_o),    64'(exp_v));
        chk({tag, ".count"},    64'(count_o),    64'(q.size()));
        chk({tag, ".empty"},    64'(empty_o),    64'(q.size() == 0));
        chk({tag, ".stall"},    64'(stall_cycles_o), exp_stall());
        if (exp_v) begin
            chk({tag, ".packet"}, 64'(out_packet_o), 64'(q[0]));
        end
    endtask

    // Called at a falling edge: drive, check, advance the model across one rising edge.
    task automatic step(input string tag, input bit v, input logic [PW-1:0] pkt,
                        input bit frz, input bit rdy, input int cred);
        bit exp_ready;
        bit exp_v;
        bit do_enq;
        bit do_deq;
        in_v_i                = v;
        in_packet_i           = pkt;
        freeze_i              = frz;
        out_credit_or_ready_i = rdy;
        out_credits_i         = CW'(cred);
        #1;
        check_outputs(tag);
        exp_ready = (q.size() != ELS);
        exp_v     = m_run && (q.size() != 0) && (cred > RES);
        do_enq    = v && exp_ready;
        do_deq    = exp_v && rdy;
        if (q.size() != 0 && !do_deq) m_stall++;
        if (do_deq) void'(q.pop_front());
        if (do_enq) q.push_back(pkt);
        m_run = !frz;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset_i = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i               = 1'b0;
        freeze_i              = 1'b0;
        in_v_i                = 1'b0;
        in_packet_i           = '0;
        out_credit_or_ready_i = 1'b1;
        out_credits_i         = CW'(200);
        model_reset();
        @(negedge clk);

        // 1: basic in-order flow, first issue one cycle after write
        do_reset("rst");
        step("t1", 1, 16'h11, 0, 1, 200);
        chk("t1.first_issue_v", 64'(out_v_o), 64'd1);
        chk("t1.first_issue_pkt", 64'(out_packet_o), 64'h11);
        step("t1", 1, 16'h22, 0, 1, 200);
        step("t1", 1, 16'h33, 0, 1, 200);
        for (int i = 0; i < 3; i++) step("t1d", 0, '0, 0, 1, 200);
        chk("t1.empty_after", 64'(empty_o), 64'd1);

        // 2/3: fill under back-pressure, fifth write held, full with simultaneous deq
        for (int i = 0; i < 5; i++) step("t2", 1, PW'(16'h100 + i), 0, 0, 200);
        chk("t2.full_ready", 64'(in_ready_o), 64'd0);
        step("t3", 1, 16'h104, 0, 1, 200);
        chk("t3.count_after_deq", 64'(count_o), 64'd3);
        chk("t3.ready_after_deq", 64'(in_ready_o), 64'd1);
        step("t3", 1, 16'h104, 0, 0, 200);
        for (int i = 0; i < 6; i++) step("t3d", 0, '0, 0, 1, 200);

        // 4: freeze with two packets queued, head retained
        step("t4", 1, 16'hA1, 0, 0, 200);
        step("t4", 1, 16'hA2, 0, 0, 200);
        step("t4f", 0, '0, 1, 0, 200);
        chk("t4.frozen_v", 64'(out_v_o), 64'd0);
        step("t4f", 0, '0, 1, 0, 200);
        step("t4u", 0, '0, 0, 0, 200);
        chk("t4.unfrozen_v", 64'(out_v_o), 64'd1);
        chk("t4.head_kept", 64'(out_packet_o), 64'hA1);

        // 5: credit reserve throttling, issue tracks credits combinationally
        step("t5", 0, '0, 0, 0, 2);
        step("t5", 0, '0, 0, 0, 2);
        step("t5", 0, '0, 0, 1, 3);
        step("t5", 0, '0, 0, 1, 3);
        step("t5", 0, '0, 0, 1, 3);

        // 6: stall statistic and async reset mid-run
        do_reset("t6rst");
        step("t6", 1, 16'h5A, 0, 0, 200);
        for (int i = 0; i < 10; i++) step("t6s", 0, '0, 0, 0, 200);
        chk("t6.stall_ten", 64'(stall_cycles_o), exp_stall());
        do_reset("t6mid");

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            int cred;
            case ($urandom_range(0, 5))
                0:       cred = 0;
                1:       cred = RES;
                2:       cred = RES + 1;
                default: cred = 200;
            endcase
            step("rnd", ($urandom_range(0, 3) != 0), PW'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), cred);
            if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
        end
        for (int i = 0; i < 10; i++) step("drain", 0, '0, 0, 1, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
